// File: rtl/ccg_pkg.sv
// Shared definitions for the sweep-and-signature harness: FSM encoding,
// default MISR taps/seed and the MISR next-state function.
package ccg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } ccg_state_e;

  localparam int          MISR_MAX_W = 32;
  localparam logic [16:0] POLY_DEF   = 17'h04001;
  localparam logic [16:0] SEED_DEF   = 17'h00000;

  // One MISR step for any width w <= MISR_MAX_W; the x^w term is implicit,
  // so the register shifts left and folds POLY back in when the msb falls out.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] fin,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    mask = (w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    fb   = (((sig >> (w - 1)) & MISR_MAX_W'(1)) != '0) ? poly : '0;
    return (((sig << 1) ^ fb) ^ fin) & mask;
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register: loads SEED on request, otherwise folds
// the benchmark response into the signature whenever enabled.
module ccg_misr
  import ccg_pkg::*;
#(
  parameter int           W    = 17,
  parameter logic [W-1:0] POLY = W'(POLY_DEF),
  parameter logic [W-1:0] SEED = W'(SEED_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] f_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (en_i) begin
      sig_d = W'(misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(f_i),
                           MISR_MAX_W'(POLY), W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/ccg_sweep_sig.sv
// Sweeps every input vector through a combinational benchmark, compresses
// the responses in a MISR and compares the final signature with a golden.
module ccg_sweep_sig
  import ccg_pkg::*;
#(
  parameter int               IN_W   = 5,
  parameter int               OUT_W  = 17,
  parameter int               SETTLE = 1,
  parameter logic [OUT_W-1:0] POLY   = OUT_W'(POLY_DEF),
  parameter logic [OUT_W-1:0] SEED   = OUT_W'(SEED_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] golden,
  output logic [IN_W-1:0]  x,
  input  logic [OUT_W-1:0] f,
  output logic             busy,
  output logic             done,
  output logic             sig_valid,
  output logic [OUT_W-1:0] signature,
  output logic             pass,
  output ccg_state_e       dbg_state
);

  localparam logic [IN_W:0] LAST_VEC = {1'b0, {IN_W{1'b1}}};
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

  ccg_state_e      state_q, state_d;
  logic [IN_W:0]   vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IN_W-1:0] x_q, x_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sig_valid_q, sig_valid_d;
  logic            pass_q, pass_d;
  logic            misr_load;
  logic            misr_en;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    sig_valid_d = sig_valid_q;
    pass_d      = pass_q;
    misr_load   = 1'b0;
    misr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (abort) begin
          sig_valid_d = 1'b0;
          pass_d      = 1'b0;
        end else if (start) begin
          state_d     = ST_APPLY;
          vec_d       = '0;
          cnt_d       = '0;
          sig_valid_d = 1'b0;
          pass_d      = 1'b0;
          misr_load   = 1'b1;
        end
      end
      ST_APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == SETTLE_C) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        sig_valid_d = 1'b1;
        pass_d      = (signature == golden);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort cancels the sweep outright; the partial signature is frozen.
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      sig_valid_d = 1'b0;
      pass_d      = 1'b0;
      misr_en     = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  assign busy_d = (state_d == ST_APPLY) || (state_d == ST_CAPTURE);
  assign done_d = (state_d == ST_DONE);
  assign x_d    = busy_d ? vec_d[IN_W-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sig_valid_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sig_valid_q <= sig_valid_d;
      pass_q      <= pass_d;
    end
  end

  ccg_misr #(
    .W   (OUT_W),
    .POLY(POLY),
    .SEED(SEED)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .load_i(misr_load),
    .en_i  (misr_en),
    .f_i   (f),
    .sig_o (signature)
  );

  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sig_valid = sig_valid_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ccg_sweep_sig.sv
// Bench for ccg_sweep_sig: instance A (SEED=0, SETTLE=1) and instance B
// (SEED=1, SETTLE=3) each driven by a behavioural benchmark circuit.
module tb_ccg_sweep_sig;
  import ccg_pkg::*;

  localparam logic [16:0] TB_POLY = 17'h04001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b, abort_a, abort_b;
  logic [16:0] golden;
  int          f_mode;

  logic [4:0]  x_a, x_b;
  logic [16:0] f_a, f_b, sig_a, sig_b;
  logic        busy_a, busy_b, done_a, done_b, sv_a, sv_b, pass_a, pass_b;
  ccg_state_e  st_a, st_b;

  // mode 0: tied low, 1: balanced netlist, 2: unbalanced netlist (same function)
  function automatic logic [16:0] bench_f(input logic [4:0] v, input int mode);
    logic [16:0] r;
    r = '0;
    if (mode != 0) begin
      r[4:0]   = v;
      r[8:5]   = v[4:1] ^ v[3:0];
      r[9]     = (v[0] & v[1]) | (v[2] & v[3]);
      r[10]    = &v;
      r[11]    = ~|v;
      r[12]    = (mode == 1) ? ((v[0] ^ v[1]) ^ (v[2] ^ v[3])) ^ v[4]
                             : v[0] ^ (v[1] ^ (v[2] ^ (v[3] ^ v[4])));
      r[13]    = (mode == 1) ? (v[0] | v[1]) & (v[2] | v[3])
                             : ((v[0] & v[2]) | (v[0] & v[3])) | ((v[1] & v[2]) | (v[1] & v[3]));
      r[16:14] = v[2:0] + 3'(v[4:3]);
    end
    return r;
  endfunction

  function automatic logic [16:0] sw_misr(input logic [16:0] seed, input int mode);
    logic [16:0] s;
    s = seed;
    for (int v = 0; v < 32; v++) begin
      s = ({s[15:0], 1'b0} ^ (s[16] ? TB_POLY : 17'h0)) ^ bench_f(5'(v), mode);
    end
    return s;
  endfunction

  assign f_a = bench_f(x_a, f_mode);
  assign f_b = bench_f(x_b, f_mode);

  ccg_sweep_sig #(.SETTLE(1), .SEED(17'h00000)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .golden(golden),
    .x(x_a), .f(f_a), .busy(busy_a), .done(done_a), .sig_valid(sv_a),
    .signature(sig_a), .pass(pass_a), .dbg_state(st_a)
  );

  ccg_sweep_sig #(.SETTLE(3), .SEED(17'h00001)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .golden(golden),
    .x(x_b), .f(f_b), .busy(busy_b), .done(done_b), .sig_valid(sv_b),
    .signature(sig_b), .pass(pass_b), .dbg_state(st_b)
  );

  // Selected-instance view used by the sweep task
  logic        sel;
  logic [4:0]  x_s;
  logic [16:0] sig_s;
  logic        busy_s, done_s, sv_s, pass_s;
  assign x_s    = sel ? x_b : x_a;
  assign sig_s  = sel ? sig_b : sig_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign sv_s   = sel ? sv_b : sv_a;
  assign pass_s = sel ? pass_b : pass_a;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          inst;
    int          mode;
    logic [16:0] gold;
    logic [16:0] exp_sig;
    bit          exp_pass;
    int          exp_busy;
    string       name;
  } vec_t;

  vec_t tbl[7];

  task automatic run_sweep(input vec_t v);
    int busy_cnt, done_cnt, x_bad, cyc, per;
    logic [16:0] got_sig;
    sel = v.inst; f_mode = v.mode; golden = v.gold;
    per = v.inst ? 4 : 2;
    @(negedge clk);
    if (v.inst) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    busy_cnt = 0; done_cnt = 0; x_bad = 0; cyc = 0; got_sig = '0;
    while (done_cnt == 0 && cyc < 400) begin
      if (busy_s) begin
        if (x_s !== 5'(busy_cnt / per)) x_bad++;
        busy_cnt++;
      end
      if (done_s) begin
        done_cnt++;
        got_sig = sig_s;
        chk({v.name, "_busy_at_done"}, busy_s, 0);
      end
      cyc++;
      if (done_cnt == 0) @(negedge clk);
    end
    chk({v.name, "_done_seen"}, done_cnt, 1);
    chk({v.name, "_busy_cycles"}, busy_cnt, v.exp_busy);
    chk({v.name, "_x_sequence"}, x_bad, 0);
    chk({v.name, "_signature"}, got_sig, v.exp_sig);
    @(negedge clk);
    chk({v.name, "_done_pulse"}, done_s, 0);
    chk({v.name, "_sig_valid"}, sv_s, 1);
    chk({v.name, "_pass"}, pass_s, v.exp_pass);
    chk({v.name, "_x_idle"}, x_s, 0);
  endtask

  initial begin
    logic [16:0] model_a, model_b;
    int n, dcnt, d1, d2;

    model_a = sw_misr(17'h00000, 1);
    model_b = sw_misr(17'h00001, 1);
    tbl[0] = '{1'b0, 0, 17'h00000, 17'h00000, 1'b1, 64,  "a_zero"};
    tbl[1] = '{1'b1, 0, 17'h0D249, 17'h0D249, 1'b1, 128, "b_zero_good"};
    tbl[2] = '{1'b1, 0, 17'h0D248, 17'h0D249, 1'b0, 128, "b_zero_bad"};
    tbl[3] = '{1'b0, 1, model_a,   model_a,   1'b1, 64,  "a_bal"};
    tbl[4] = '{1'b0, 2, model_a,   model_a,   1'b1, 64,  "a_unbal"};
    tbl[5] = '{1'b1, 1, model_b,   model_b,   1'b1, 128, "b_bal"};
    tbl[6] = '{1'b0, 1, 17'h00000, model_a,   (model_a == 17'h0), 64, "a_bal_badgold"};

    rst = 1'b1; start_a = 0; start_b = 0; abort_a = 0; abort_b = 0;
    golden = '0; f_mode = 0; sel = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x_a", x_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_sv_a", sv_a, 0);
    chk("rst_pass_a", pass_a, 0);
    chk("rst_sig_a", sig_a, 17'h00000);
    chk("rst_sig_b", sig_b, 17'h00001);
    chk("rst_state_b", st_b, ST_IDLE);

    for (int i = 0; i < 7; i++) run_sweep(tbl[i]);

    // Abort at vector 10, then a clean rerun must reproduce the signature
    sel = 0; f_mode = 1; golden = model_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (x_a != 5'd10 && n < 200) begin @(negedge clk); n++; end
    chk("abort_reach_vec10", x_a, 10);
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_x", x_a, 0);
    chk("abort_sv", sv_a, 0);
    chk("abort_pass", pass_a, 0);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_a) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_state", st_a, ST_IDLE);
    run_sweep(tbl[3]);

    // Asynchronous reset in the middle of an APPLY cycle
    sel = 0; f_mode = 1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (!(st_a == ST_APPLY && x_a >= 5'd3) && n < 200) begin @(negedge clk); n++; end
    chk("rstmid_reach_apply", st_a, ST_APPLY);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_x", x_a, 0);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_done", done_a, 0);
    chk("rstmid_sv", sv_a, 0);
    chk("rstmid_pass", pass_a, 0);
    chk("rstmid_sig", sig_a, 17'h00000);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_no_resume", busy_a, 0);

    // start held high: one sweep per IDLE visit, done pulses 66 cycles apart
    sel = 0; f_mode = 1; golden = model_a;
    @(negedge clk); start_a = 1'b1;
    dcnt = 0; d1 = 0; d2 = 0;
    for (int c = 0; c < 300 && dcnt < 2; c++) begin
      @(negedge clk);
      if (done_a) begin
        dcnt++;
        if (dcnt == 1) d1 = c; else d2 = c;
        if (dcnt == 2) start_a = 1'b0;
      end
    end
    chk("held_two_done", dcnt, 2);
    chk("held_spacing", d2 - d1, 66);
    chk("held_sig", sig_a, model_a);
    repeat (3) @(negedge clk);
    chk("held_stop", busy_a, 0);
    chk("held_pass", pass_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
